// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use hazard detection, downstream hold and flush.
module id_ex_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [3:0]  id_funct_c,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        id_alu_src,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_reg_write,
    input  logic [31:0] exmem_result,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_reg_write,
    input  logic [31:0] memwb_result,
    input  logic        flush,
    input  logic        ex_stall,
    output logic [3:0]  funct_c,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic [4:0]  ex_rd,
    output logic        stall_id
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned FUNC_W = 4;

    logic              valid_q;
    logic [FUNC_W-1:0] funct_q;
    logic [REG_W-1:0]  rs_q;
    logic [REG_W-1:0]  rt_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              alu_src_q;
    logic              reg_write_q;
    logic              mem_read_q;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // EX/MEM beats MEM/WB; register 0 is never forwarded.
    function automatic logic [DATA_W-1:0] forward(
        input logic [REG_W-1:0]  src,
        input logic [DATA_W-1:0] stored,
        input logic [REG_W-1:0]  em_rd,
        input logic              em_we,
        input logic [DATA_W-1:0] em_res,
        input logic [REG_W-1:0]  mw_rd,
        input logic              mw_we,
        input logic [DATA_W-1:0] mw_res
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if (em_we && (em_rd != REG_W'(0)) && (em_rd == src)) begin
            v = em_res;
        end else if (mw_we && (mw_rd != REG_W'(0)) && (mw_rd == src)) begin
            v = mw_res;
        end
        return v;
    endfunction

    always_comb begin
        fwd_rs = forward(rs_q, rs_data_q, exmem_rd, exmem_reg_write, exmem_result,
                         memwb_rd, memwb_reg_write, memwb_result);
        fwd_rt = forward(rt_q, rt_data_q, exmem_rd, exmem_reg_write, exmem_result,
                         memwb_rd, memwb_reg_write, memwb_result);
    end

    always_comb begin
        a = fwd_rs;
        b = alu_src_q ? imm_q : fwd_rt;
    end

    // Load in EX whose destination feeds the instruction waiting in ID.
    always_comb begin
        stall_id = valid_q && mem_read_q && (rd_q != REG_W'(0)) && id_valid &&
                   ((rd_q == id_rs) || (rd_q == id_rt)) && !ex_stall;
    end

    always_ff @(posedge clk) begin
        if (reset || flush || (!ex_stall && stall_id)) begin
            valid_q     <= 1'b0;
            funct_q     <= FUNC_W'(0);
            rs_q        <= REG_W'(0);
            rt_q        <= REG_W'(0);
            rd_q        <= REG_W'(0);
            rs_data_q   <= DATA_W'(0);
            rt_data_q   <= DATA_W'(0);
            imm_q       <= DATA_W'(0);
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (ex_stall) begin
            // Capture forwarded values so producers retiring during the hold are not lost.
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end else begin
            valid_q     <= id_valid;
            funct_q     <= id_funct_c;
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            rd_q        <= id_rd;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            alu_src_q   <= id_alu_src;
            reg_write_q <= id_reg_write && id_valid;
            mem_read_q  <= id_mem_read && id_valid;
        end
    end

    always_comb begin
        funct_c      = funct_q;
        ex_valid     = valid_q;
        ex_reg_write = reg_write_q;
        ex_mem_read  = mem_read_q;
        ex_rd        = rd_q;
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage for the 32-bit MIPS datapath; sits directly upstream of the ALU function-select block and drives its FunctC, A and B inputs. It captures decoded instruction fields once per cycle and forwards results from EX/MEM and MEM/WB. It detects load-use hazards and stalls ID, and supports downstream hold and flush.

## Interface
Parameters:
- none (datapath 32 bits, register index 5 bits, fixed)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID presents a real instruction
- id_funct_c  in  4  ALU code: 0000 AND, 0001 ADD, 0010 SUB, 0110 SUB(cin=1), 1010 MUL, 0011 NOT
- id_rs, id_rt, id_rd  in  5 each  source/destination register indices
- id_rs_data, id_rt_data  in  32 each  register-file read data
- id_imm  in  32  sign/zero-extended immediate
- id_alu_src  in  1  1 = B from immediate
- id_reg_write, id_mem_read  in  1 each  control bits carried to EX
- exmem_rd  in  5; exmem_reg_write  in  1; exmem_result  in  32
- memwb_rd  in  5; memwb_reg_write  in  1; memwb_result  in  32
- flush  in  1  kill the instruction entering EX
- ex_stall  in  1  EX cannot accept; hold contents
- funct_c  out  4  to ALU select FunctC
- a, b  out  32 each  forwarded operands to ALU select
- ex_valid, ex_reg_write, ex_mem_read  out  1 each
- ex_rd  out  5
- stall_id  out  1  freeze PC and IF/ID this cycle

## Operation
- Stored state: valid, funct_c, rs, rt, rd, rs_data, rt_data, imm, alu_src, reg_write, mem_read.
- Forwarding (combinational from stored state): for each of rs and rt, the forwarded value is exmem_result when exmem_reg_write is set, exmem_rd equals the register and exmem_rd is not 0. Otherwise it is memwb_result under the same test on the MEM/WB fields. Otherwise it is the stored data. EX/MEM takes priority over MEM/WB. Register 0 is never forwarded.
- a = forwarded rs. b = stored imm when alu_src is set, else forwarded rt.
- Load-use: stall_id = valid & mem_read & rd≠0 & id_valid & (rd==id_rs | rd==id_rt) & !ex_stall. It is combinational.
- Clock-edge update priority:
  1. reset: clear everything.
  2. flush: load a bubble.
  3. ex_stall: hold all fields, but overwrite rs_data/rt_data with their forwarded values. This refresh prevents the loss of results that leave EX/MEM or MEM/WB during the hold.
  4. stall_id: load a bubble. The ID instruction stays in ID and is re-presented.
  5. otherwise: load ID fields. valid is set to id_valid; reg_write and mem_read are gated by id_valid.
- Bubble: valid=0, reg_write=0, mem_read=0, funct_c=0000, rd=0, rs=rt=0, all data 0.
- Invalid entries still drive a/b but never assert reg_write/mem_read.

## Timing
- Reset values: funct_c=0000, a=0, b=0, ex_valid=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0, stall_id=0.
- Latency: ID fields appear on outputs 1 cycle after capture. Forwarding paths are 0-cycle (same cycle as exmem/memwb inputs).
- A load-use hazard costs exactly 1 bubble. In the next cycle the load is in EX/MEM, stall_id drops, and the dependent instruction is captured and forwarded from MEM/WB two cycles later.
- Simultaneous flush + ex_stall: flush wins and a bubble is loaded.
- Simultaneous flush + stall_id: a bubble is loaded, and stall_id is still asserted that cycle.
- Reset asserted mid-stall: all state clears on that edge, and stall_id is 0 in the following cycle.
- Back-to-back identical rd in EX/MEM and MEM/WB: the EX/MEM value is used.

## Test plan
- Reset:
  - Stimulus: hold reset 2 cycles with id_valid=1.
  - Required response: all outputs 0, ex_valid=0.
- Plain capture:
  - Stimulus: id_funct_c=0001, rs_data=5, rt_data=7, alu_src=0, no forwarding.
  - Required response: next cycle funct_c=0001, a=5, b=7, ex_valid=1.
- Forwarding priority:
  - Stimulus: stored rs=3; exmem_rd=3 with result 0x11, memwb_rd=3 with result 0x22.
  - Required response: a=0x11. Drop exmem_reg_write and a=0x22 is required. Set rd=0 in both stages and the stored value is required.
- Load-use:
  - Stimulus: an EX lw with rd=4, then ID add with rs=4.
  - Required response: stall_id=1 for one cycle and a bubble is loaded (ex_valid=0). The add then enters with a=memwb_result once the load reaches MEM/WB.
- Hold refresh:
  - Stimulus: ex_stall=1 for 3 cycles while the producing rd=6, value 0x99, moves from EX/MEM through MEM/WB and out.
  - Required response: a=0x99 throughout and after release. Outputs are otherwise unchanged.
- Flush vs stall:
  - Stimulus: assert flush and ex_stall together.
  - Required response: next cycle ex_valid=0, ex_reg_write=0, funct_c=0000.
